// File: rtl/tcdm_bank_responder.sv
// TCDM bank endpoint: byte-enabled storage, fixed-latency load responses, optional refresh windows that block grants.
// Build option: define TCDM_BANK_RESP_POISON_EN to drive a poison pattern on rdata_o whenever no load response is due.
module tcdm_bank_responder #(
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned BeWidth       = DataWidth / 8,
    parameter int unsigned AddrMemWidth  = 12,
    parameter int unsigned RespLat       = 1,
    parameter int unsigned RefreshPeriod = 0,
    parameter int unsigned RefreshCycles = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [AddrMemWidth-1:0] add_i,
    input  logic                    wen_i,
    input  logic [DataWidth-1:0]    wdata_i,
    input  logic [BeWidth-1:0]      be_i,
    output logic [DataWidth-1:0]    rdata_o,
    output logic                    refresh_o,
    output logic [31:0]             acc_cnt_o
);

    localparam int unsigned NumWords = 2 ** AddrMemWidth;
    localparam int unsigned CntWidth = 32;

    typedef enum logic {
        Active  = 1'b0,
        Refresh = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic                  accept;
    logic                  load_acc;

    logic [DataWidth-1:0]  mem [NumWords];
    logic [DataWidth-1:0]  pipe_data_q [RespLat];
    logic [RespLat-1:0]    pipe_valid_q;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Active;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: refresh windows are time-driven and ignore req_i
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            Active: begin
                if (RefreshPeriod > 0) begin
                    if (cnt_q == CntWidth'(RefreshPeriod - 1)) begin
                        state_d = Refresh;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntWidth'(1);
                    end
                end
            end
            Refresh: begin
                if (cnt_q == CntWidth'(RefreshCycles - 1)) begin
                    state_d = Active;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntWidth'(1);
                end
            end
            default: begin
                state_d = Active;
                cnt_d   = '0;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        gnt_o     = 1'b0;
        refresh_o = 1'b0;
        if (state_q == Active) begin
            gnt_o = req_i;
        end else begin
            refresh_o = 1'b1;
        end
    end

    assign accept   = req_i & gnt_o;
    assign load_acc = accept & ~wen_i;

    // Storage array is intentionally not reset
    always_ff @(posedge clk_i) begin
        if (accept && wen_i) begin
            for (int unsigned b = 0; b < BeWidth; b++) begin
                if (be_i[b]) begin
                    mem[add_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Load pipeline; each stage only advances on a valid entry so the last stage holds the last response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pipe_valid_q <= '0;
            for (int unsigned i = 0; i < RespLat; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_valid_q[0] <= load_acc;
            if (load_acc) begin
                pipe_data_q[0] <= mem[add_i];
            end
            for (int unsigned i = 1; i < RespLat; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                if (pipe_valid_q[i-1]) begin
                    pipe_data_q[i] <= pipe_data_q[i-1];
                end
            end
        end
    end

`ifdef TCDM_BANK_RESP_POISON_EN
    localparam int unsigned PoisonReps = (DataWidth + 31) / 32;
    localparam logic [PoisonReps*32-1:0] PoisonWide = {PoisonReps{32'hBADCAB1E}};
    localparam logic [DataWidth-1:0] Poison = PoisonWide[DataWidth-1:0];

    assign rdata_o = pipe_valid_q[RespLat-1] ? pipe_data_q[RespLat-1] : Poison;
`else
    logic unused_last_valid;

    assign unused_last_valid = pipe_valid_q[RespLat-1];
    assign rdata_o           = pipe_data_q[RespLat-1];
`endif

    // Granted-request counter, wraps naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_cnt_o <= '0;
        end else if (accept) begin
            acc_cnt_o <= acc_cnt_o + 32'd1;
        end
    end

`ifndef SYNTHESIS
    if (RespLat < 1) begin : g_bad_resp_lat
        $error("tcdm_bank_responder: RespLat must be >= 1");
    end
    if ((RefreshPeriod > 0) && (RefreshCycles < 1)) begin : g_bad_refresh_cycles
        $error("tcdm_bank_responder: RefreshCycles must be >= 1 when refresh is enabled");
    end

    // A stalled request must keep its payload until granted
    a_req_stable: assert property (
        @(posedge clk_i) disable iff (!rst_ni)
        (req_i && !gnt_o) |=> (!req_i || $stable({add_i, wen_i, wdata_i, be_i}))
    );
`endif

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Scoreboard bench for tcdm_bank_responder with RespLat=3 and refresh enabled (period 8, window 2).
// Load responses are queued with their due cycle when accepted and compared when that cycle arrives.
module tb_tcdm_bank_responder;

    localparam int unsigned RL = 3;
    localparam int unsigned RP = 8;
    localparam int unsigned RC = 2;
    localparam logic [31:0] POISON_WORD = 32'hBADCAB1E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        gnt;
    logic [11:0] add = '0;
    logic        wen = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        refresh;
    logic [31:0] acc_cnt;

    tcdm_bank_responder #(
        .DataWidth    (32),
        .BeWidth      (4),
        .AddrMemWidth (12),
        .RespLat      (RL),
        .RefreshPeriod(RP),
        .RefreshCycles(RC)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .req_i    (req),
        .gnt_o    (gnt),
        .add_i    (add),
        .wen_i    (wen),
        .wdata_i  (wdata),
        .be_i     (be),
        .rdata_o  (rdata),
        .refresh_o(refresh),
        .acc_cnt_o(acc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [16];
    logic [31:0] last_data = '0;
    int unsigned exp_acc = 0;
    int unsigned cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Cycles since reset release; refresh phase is derived from it
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Per-cycle monitor, sampled well after inputs settle
    always @(negedge clk) begin
        logic exp_ref;
        #2;
        if (rst_n) begin
            exp_ref = ((cyc % (RP + RC)) >= RP);
            check("refresh", 32'(refresh), 32'(exp_ref));
            check("gnt", 32'(gnt), 32'(req & ~exp_ref));
            check("acc_cnt", acc_cnt, exp_acc);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rdata", rdata, sb[0].data);
                last_data = sb[0].data;
                void'(sb.pop_front());
            end else begin
`ifdef TCDM_BANK_RESP_POISON_EN
                check("rdata_idle", rdata, POISON_WORD);
`else
                check("rdata_hold", rdata, last_data);
`endif
            end
        end
    end

    task automatic xact(input logic w, input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        int unsigned due;
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        req = 1'b1; wen = w; add = 12'(a); wdata = d; be = b;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (gnt) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check("gnt_timeout", 32'(gnt), 32'd1);
            req = 1'b0;
        end else begin
            due = cyc + RL;
            @(posedge clk);
            exp_acc++;
            if (w) begin
                for (int k = 0; k < 4; k++) begin
                    if (b[k]) mdl[a][8*k +: 8] = d[8*k +: 8];
                end
            end else begin
                sb.push_back(exp_t'{due, mdl[a]});
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk);
            req = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 1'b0; wen = 1'b0; add = '0; wdata = '0; be = '0;
        sb.delete();
        exp_acc   = 0;
        last_data = '0;
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_refresh", 32'(refresh), 32'd0);
        check("rst_acc_cnt", acc_cnt, 32'd0);
`ifdef TCDM_BANK_RESP_POISON_EN
        check("rst_rdata", rdata, POISON_WORD);
`else
        check("rst_rdata", rdata, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Preload a known value into every address the bench touches
        for (int i = 0; i < 16; i++) xact(1'b1, 4'(i), $urandom, 4'hF);
        idle(2);

        // Full store then load
        xact(1'b1, 4'd5, 32'hCAFEF00D, 4'hF);
        xact(1'b0, 4'd5, 32'd0, 4'h0);
        idle(5);

        // Partial write merges bytes 0 and 2 only
        xact(1'b1, 4'd7, 32'h11223344, 4'hF);
        xact(1'b1, 4'd7, 32'hAABBCCDD, 4'b0101);
        xact(1'b0, 4'd7, 32'd0, 4'h0);
        idle(5);

        // Back-to-back pipelined loads
        xact(1'b1, 4'd0, 32'h0000000A, 4'hF);
        xact(1'b1, 4'd1, 32'h0000000B, 4'hF);
        xact(1'b1, 4'd2, 32'h0000000C, 4'hF);
        xact(1'b0, 4'd0, 32'd0, 4'h0);
        xact(1'b0, 4'd1, 32'd0, 4'h0);
        xact(1'b0, 4'd2, 32'd0, 4'h0);
        idle(6);

        // Zero byte-enable store is a granted no-op
        xact(1'b1, 4'd5, 32'h55555555, 4'h0);
        xact(1'b0, 4'd5, 32'd0, 4'h0);
        idle(5);

        // Random mixed traffic
        for (int i = 0; i < 40; i++) begin
            xact(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(5);

        // Request held high across several refresh windows
        for (int i = 0; i < 25; i++) xact(1'b0, 4'(i % 3), 32'd0, 4'h0);
        idle(6);

        // Reset with a load in flight: nothing may emerge afterwards
        xact(1'b0, 4'd7, 32'd0, 4'h0);
        do_reset();
        idle(8);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
